// File: rtl/ones_run_tx.sv
// Serial run-length transmitter: each accepted length becomes a burst of 1s
// followed by GAP zero cycles, plus a shadow of the mod-4 ones-count detector.
module ones_run_tx #(
    parameter int LEN_W = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LEN_W-1:0] in_len,
    output logic             x_out,
    output logic             busy,
    output logic             done,
    output logic [1:0]       exp_state,
    output logic             exp_y,
    output logic [1:0]       dbg_state
);

    // Handshake: a run is accepted on a rising edge where in_valid && in_ready.
    // in_ready is high only in IDLE; in_valid elsewhere is ignored and in_len
    // is captured only at the accepting edge.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONES = 2'd1,
        GAPS = 2'd2
    } state_t;

    localparam logic [3:0] GAP_L = 4'(GAP);

    state_t           r_state;
    logic [LEN_W-1:0] r_cnt;
    logic [3:0]       r_gcnt;
    logic             r_x;
    logic             r_busy;
    logic             r_done;
    logic [1:0]       r_exp_state;

    state_t           w_next_state;
    logic [LEN_W-1:0] w_next_cnt;
    logic [3:0]       w_next_gcnt;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_gcnt  = r_gcnt;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next_cnt = in_len;
                    if (in_len != '0) begin
                        w_next_state = ONES;
                    end else begin
                        w_next_state = GAPS;
                        w_next_gcnt  = GAP_L;
                    end
                end
            end
            ONES: begin
                w_next_cnt = r_cnt - LEN_W'(1);
                if (r_cnt == LEN_W'(1)) begin
                    w_next_state = GAPS;
                    w_next_gcnt  = GAP_L;
                end
            end
            GAPS: begin
                w_next_gcnt = r_gcnt - 4'd1;
                if (r_gcnt == 4'd1) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Outputs are flopped from the next-state values so x_out is glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_gcnt      <= '0;
            r_x         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_exp_state <= 2'd0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_gcnt      <= w_next_gcnt;
            r_x         <= (w_next_state == ONES);
            r_busy      <= (w_next_state != IDLE);
            r_done      <= (w_next_state == GAPS) && (w_next_gcnt == 4'd1);
            r_exp_state <= r_x ? (r_exp_state + 2'd1) : 2'd0;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign x_out     = r_x;
    assign busy      = r_busy;
    assign done      = r_done;
    assign exp_state = r_exp_state;
    // Detector is Mealy: it outputs 1 only in S2/S3 while the input is 1.
    assign exp_y     = r_x & r_exp_state[1];
    assign dbg_state = r_state;

endmodule

// File: tb/tb_ones_run_tx.sv
// Bench for ones_run_tx: two instances (GAP=1 and GAP=2) share stimulus and are
// compared every cycle against a run/gap counting model, plus directed literals.
module tb_ones_run_tx;
  localparam int LEN_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [LEN_W-1:0] in_len = '0;
  logic             in_ready [2];
  logic             x_out [2];
  logic             busy [2];
  logic             done [2];
  logic             exp_y [2];
  logic [1:0]       exp_state [2];
  logic [1:0]       dbg_state [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ones_run_tx #(.LEN_W(LEN_W), .GAP(g + 1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[g]),
      .in_len(in_len), .x_out(x_out[g]), .busy(busy[g]), .done(done[g]),
      .exp_state(exp_state[g]), .exp_y(exp_y[g]), .dbg_state(dbg_state[g])
    );
  end

  // Model: ones still to send, gap zeros still to send, consecutive-ones count mod 4.
  int m_ones [2] = '{0, 0};
  int m_gaps [2] = '{0, 0};
  int m_st [2] = '{0, 0};

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        m_ones[g] <= 0;
        m_gaps[g] <= 0;
        m_st[g]   <= 0;
      end else begin
        m_st[g] <= (m_ones[g] > 0) ? (m_st[g] + 1) % 4 : 0;
        if (m_ones[g] > 0) m_ones[g] <= m_ones[g] - 1;
        else if (m_gaps[g] > 0) m_gaps[g] <= m_gaps[g] - 1;
        else if (in_valid) begin
          m_ones[g] <= int'(in_len);
          m_gaps[g] <= g + 1;
        end
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d] cycle %0d: got %0d expected %0d", name, g, cyc, act, exp);
    end
  endtask

  // Advance to the next falling edge and compare every output with the model.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int g = 0; g < 2; g++) begin
      chk("x_out", g, 32'(x_out[g]), 32'(m_ones[g] > 0));
      chk("busy", g, 32'(busy[g]), 32'(m_ones[g] > 0 || m_gaps[g] > 0));
      chk("done", g, 32'(done[g]), 32'(m_ones[g] == 0 && m_gaps[g] == 1));
      chk("in_ready", g, 32'(in_ready[g]), 32'(m_ones[g] == 0 && m_gaps[g] == 0));
      chk("exp_state", g, 32'(exp_state[g]), 32'(m_st[g]));
      chk("exp_y", g, 32'(exp_y[g]), 32'(m_ones[g] > 0 && m_st[g] >= 2));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_len = '0;
    step();
    rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk("rst_x", g, 32'(x_out[g]), 0);
      chk("rst_busy", g, 32'(busy[g]), 0);
      chk("rst_done", g, 32'(done[g]), 0);
      chk("rst_state", g, 32'(exp_state[g]), 0);
      chk("rst_y", g, 32'(exp_y[g]), 0);
      chk("rst_ready", g, 32'(in_ready[g]), 1);
    end
  endtask

  int r3_x [5] = '{1, 1, 1, 0, 0};
  int r3_s [5] = '{0, 1, 2, 3, 0};
  int r3_y [5] = '{0, 0, 1, 0, 0};
  int r3_d [5] = '{0, 0, 0, 1, 0};
  int w6_s [7] = '{0, 1, 2, 3, 0, 1, 2};
  int w6_y [7] = '{0, 0, 1, 1, 0, 0, 0};

  initial begin
    int hs [$];
    int ones;

    do_reset();

    // Run of 3 on the GAP=1 instance.
    in_valid = 1'b1;
    in_len = 4'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      in_valid = 1'b0;
      chk("r3_x", 0, 32'(x_out[0]), 32'(r3_x[i]));
      chk("r3_state", 0, 32'(exp_state[0]), 32'(r3_s[i]));
      chk("r3_y", 0, 32'(exp_y[0]), 32'(r3_y[i]));
      chk("r3_done", 0, 32'(done[0]), 32'(r3_d[i]));
    end

    // Run of 6: detector count wraps 3 -> 0.
    do_reset();
    in_valid = 1'b1;
    in_len = 4'd6;
    for (int i = 0; i < 7; i++) begin
      step();
      in_valid = 1'b0;
      chk("w6_state", 0, 32'(exp_state[0]), 32'(w6_s[i]));
      chk("w6_y", 0, 32'(exp_y[0]), 32'(w6_y[i]));
    end

    // Zero length: gap only.
    do_reset();
    in_valid = 1'b1;
    in_len = 4'd0;
    step();
    in_valid = 1'b0;
    chk("z_x", 1, 32'(x_out[1]), 0);
    chk("z_done1", 1, 32'(done[1]), 0);
    chk("z_ready1", 1, 32'(in_ready[1]), 0);
    chk("z_done0", 0, 32'(done[0]), 1);
    step();
    chk("z_done2", 1, 32'(done[1]), 1);
    chk("z_x2", 1, 32'(x_out[1]), 0);
    step();
    chk("z_ready3", 1, 32'(in_ready[1]), 1);

    // Back-to-back with in_valid held: lengths 2 then 4.
    do_reset();
    in_valid = 1'b1;
    in_len = 4'd2;
    for (int i = 0; i < 20 && hs.size() < 2; i++) begin
      if (in_ready[0] === 1'b1) hs.push_back(cyc);
      step();
      if (hs.size() == 1) in_len = 4'd4;
    end
    in_valid = 1'b0;
    chk("b2b_hs_count", 0, 32'(hs.size()), 2);
    if (hs.size() == 2) chk("b2b_spacing", 0, 32'(hs[1] - hs[0]), 4);
    chk("b2b_x", 0, 32'(x_out[0]), 1);
    chk("b2b_state", 0, 32'(exp_state[0]), 0);

    // Reset during the 2nd one of a 5-run, then a run of 1.
    do_reset();
    in_valid = 1'b1;
    in_len = 4'd5;
    step();
    in_valid = 1'b0;
    step();
    chk("mr_x_before", 0, 32'(x_out[0]), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_x", 0, 32'(x_out[0]), 0);
    chk("mr_state", 0, 32'(exp_state[0]), 0);
    chk("mr_ready", 0, 32'(in_ready[0]), 1);
    in_valid = 1'b1;
    in_len = 4'd1;
    step();
    in_valid = 1'b0;
    chk("mr_x1", 0, 32'(x_out[0]), 1);
    chk("mr_y1", 0, 32'(exp_y[0]), 0);
    step();
    chk("mr_x2", 0, 32'(x_out[0]), 0);
    chk("mr_y2", 0, 32'(exp_y[0]), 0);

    // Inputs toggled during ONES must not change the captured run of 5.
    do_reset();
    in_valid = 1'b1;
    in_len = 4'd5;
    ones = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (x_out[0] === 1'b1) ones++;
      if (i < 3) begin
        in_valid = 1'($urandom_range(0, 1));
        in_len = 4'($urandom_range(0, 15));
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("ign_run_len", 0, 32'(ones), 5);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_len = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 60) == 0);
      step();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ones_run_tx.md
# ones_run_tx

Serial run-length transmitter. It accepts run lengths over a valid/ready handshake and drives a single-bit stream on `x_out`. Each run is a burst of consecutive 1s followed by a zero gap. The stream feeds our mod-4 ones-count Mealy detector. A built-in shadow model of that detector drives `exp_state`/`exp_y`, so benches and on-chip checkers can compare the detector's `state`/`y_out` against expected values every cycle.

## Interface
- `LEN_W`, default 4: width of run length; max run = 2^LEN_W-1.
- `GAP`, default 1: number of zero cycles after each run; legal range 1..15.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset; one clock, synchronous reset, sampled on rising `clk`.
- `in_valid`  in  1  run length on `in_len` is valid.
- `in_ready`  out  1  block can accept a run; high only in IDLE.
- `in_len`  in  LEN_W  number of 1s to emit; 0 is legal (gap only).
- `x_out`  out  1  registered serial stream to the detector's `x_in`.
- `busy`  out  1  high in ONES or GAPS.
- `done`  out  1  one-cycle pulse on the last gap cycle of each run.
- `exp_state`  out  2  expected detector state (S0..S3 = 0..3) for the current cycle.
- `exp_y`  out  1  expected detector output for the current cycle.

## Operation
- FSM states are IDLE, ONES and GAPS.
  - IDLE: `x_out`=0, `in_ready`=1. On `in_valid & in_ready`, latch `in_len` into `cnt`.
    - `in_len`≠0: go to ONES.
    - `in_len`=0: go to GAPS with `gcnt`=GAP.
  - ONES: `x_out`=1. Decrement `cnt` each cycle. When `cnt`=1, go to GAPS with `gcnt`=GAP.
  - GAPS: `x_out`=0. Decrement `gcnt` each cycle. When `gcnt`=1, assert `done` and go to IDLE.
- `in_ready` = (state==IDLE). `in_valid` outside IDLE is ignored; the source holds it.
- `in_len` is captured only at the handshake. Later changes do not affect the run in flight.
- Shadow detector, updated every clock from `x_out`:
  - Next `exp_state`: (`exp_state`+1) mod 4 if `x_out`=1, else 0.
  - `exp_y` = `x_out` & `exp_state[1]`, combinational from registered values. This matches the detector's Mealy output of 1 only in S2/S3 with `x_in`=1.
- Counter wrap: `exp_state` wraps 3→0 on a 1. Runs longer than 4 therefore give the `exp_y` pattern 0,0,1,1 repeating.
- Reset (`rst`=1 at an edge), including mid-run:
  - Next state IDLE; `x_out`, `done`, `busy`=0.
  - `cnt`, `gcnt`, `exp_state`=0.
  - `rst` has priority over a simultaneous handshake; that handshake is dropped.
  - `in_ready` reads 1 once the state is IDLE.

## Timing
- Handshake at edge k.
  - `x_out`=1 for cycles k+1..k+`len`.
  - `x_out`=0 for cycles k+`len`+1..k+`len`+GAP.
  - `done` is high in cycle k+`len`+GAP.
  - IDLE and `in_ready`=1 in cycle k+`len`+GAP+1.
- Throughput: one run per `len`+GAP+1 cycles. The IDLE cycle adds one more zero, so the effective gap is GAP+1.
- `exp_state` in cycle c equals the detector's `state` in cycle c, given a shared `clk` and a detector reset in the same cycle. `exp_y` matches `y_out` in every cycle.
- All outputs after reset: `x_out`=0, `busy`=0, `done`=0, `exp_state`=0, `exp_y`=0, `in_ready`=1.

## Test plan
- Run of 3, GAP=1: `in_len`=3 → `x_out` 1,1,1,0 then 0 (IDLE); `exp_state` 0,1,2,3,0; `exp_y` 0,0,1,0,0; `done` high in the 4th cycle.
- Wrap, `in_len`=6: `x_out` 1×6 then 0 → `exp_state` 0,1,2,3,0,1,2; `exp_y` 0,0,1,1,0,0,0.
- Zero length, `in_len`=0, GAP=2: `x_out` stays 0 for 2 cycles; `done` on the 2nd; `in_ready` returns on the 3rd.
- Back-to-back, with `in_valid` held and `in_len`=2 then 4: handshakes are exactly 4 cycles apart (2+1+1); the 2nd run's ones start from `exp_state`=0.
- Mid-run reset: `rst` pulsed during the 2nd one of a 5-run → next cycle `x_out`=0, `exp_state`=0, `in_ready`=1; a new `in_len`=1 gives `x_out` 1,0 with `exp_y` 0,0.
- Ignored input: toggle `in_len` and `in_valid` during ONES → no extra handshake; the emitted run length equals the captured value.
